// File: rtl/etc_pkg.sv
// rtl/etc_pkg.sv - shared constants and state encoding for the ETC image store controller
package etc_pkg;

  localparam int IMG_W_DEF = 128;
  localparam int IMG_H_DEF = 128;
  localparam int ETC_BLK   = 4;
  localparam int ETC_PIX   = ETC_BLK * ETC_BLK;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Counter width for n states, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/etc_store_ctrl_if.sv
// rtl/etc_store_ctrl_if.sv - decoded pixel stream in, image store write port out
interface etc_store_ctrl_if;

  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  pix_r;
  logic [7:0]  pix_g;
  logic [7:0]  pix_b;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;
  logic        rgb_rtr;
  logic [31:0] write_addr;

  modport master (
    output pix_valid, pix_r, pix_g, pix_b,
    input  pix_ready, r, g, b, rgb_rtr, write_addr
  );

  modport slave (
    input  pix_valid, pix_r, pix_g, pix_b,
    output pix_ready, r, g, b, rgb_rtr, write_addr
  );

endinterface

// File: rtl/etc_addr_gen.sv
// rtl/etc_addr_gen.sv - maps (block x, block y, ETC pixel index) to a raster address
module etc_addr_gen
  import etc_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int BXW   = cnt_w(IMG_W / ETC_BLK),
  parameter int BYW   = cnt_w(IMG_H / ETC_BLK)
) (
  input  logic [BXW-1:0] i_bx,
  input  logic [BYW-1:0] i_by,
  input  logic [3:0]     i_p,
  output logic [31:0]    o_addr
);

  logic [31:0] w_row;
  logic [31:0] w_col;

  // ETC pixel order is column-major inside the block: x = p[3:2], y = p[1:0].
  assign w_row  = 32'(i_by) * 32'(ETC_BLK) + 32'(i_p[1:0]);
  assign w_col  = 32'(i_bx) * 32'(ETC_BLK) + 32'(i_p[3:2]);
  assign o_addr = w_row * 32'(IMG_W) + w_col;

endmodule

// File: rtl/etc_store_ctrl.sv
// rtl/etc_store_ctrl.sv - writes ETC-ordered decoded pixels into a raster image store
module etc_store_ctrl
  import etc_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic            sclk,
  input  logic            rsrt,
  input  logic            frame_start,
  etc_store_ctrl_if.slave bus,
  output logic            image_finished,
  output logic            busy
);

  localparam int BXN = IMG_W / ETC_BLK;
  localparam int BYN = IMG_H / ETC_BLK;
  localparam int BXW = cnt_w(BXN);
  localparam int BYW = cnt_w(BYN);
  localparam logic [BXW-1:0] BX_LAST = BXW'(BXN - 1);
  localparam logic [BYW-1:0] BY_LAST = BYW'(BYN - 1);
  localparam logic [3:0]     P_LAST  = 4'(ETC_PIX - 1);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [3:0]     r_p;
  logic [BXW-1:0] r_bx;
  logic [BYW-1:0] r_by;
  logic           r_pix_ready;
  logic           r_busy;
  logic           r_img_fin;
  logic           r_rgb_rtr;
  logic [7:0]     r_r;
  logic [7:0]     r_g;
  logic [7:0]     r_b;
  logic [31:0]    r_waddr;
  logic           w_accept;
  logic           w_last;
  logic [31:0]    w_addr;

  etc_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .BXW   (BXW),
    .BYW   (BYW)
  ) u_addr_gen (
    .i_bx   (r_bx),
    .i_by   (r_by),
    .i_p    (r_p),
    .o_addr (w_addr)
  );

  // A restart in the same cycle as a handshake drops that pixel.
  assign w_accept = bus.pix_valid && r_pix_ready && !frame_start;
  assign w_last   = (r_p == P_LAST) && (r_bx == BX_LAST) && (r_by == BY_LAST);

  always_comb begin
    w_state_nxt = r_state;
    if (frame_start) begin
      w_state_nxt = ST_WRITE;
    end else if ((r_state == ST_WRITE) && w_accept && w_last) begin
      w_state_nxt = ST_DONE;
    end
  end

  always_ff @(posedge sclk) begin
    if (!rsrt) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge sclk) begin
    if (!rsrt) begin
      r_p  <= '0;
      r_bx <= '0;
      r_by <= '0;
    end else if (frame_start) begin
      r_p  <= '0;
      r_bx <= '0;
      r_by <= '0;
    end else if (w_accept) begin
      r_p <= r_p + 4'd1;
      if (r_p == P_LAST) begin
        if (r_bx == BX_LAST) begin
          r_bx <= '0;
          r_by <= (r_by == BY_LAST) ? '0 : r_by + BYW'(1);
        end else begin
          r_bx <= r_bx + BXW'(1);
        end
      end
    end
  end

  always_ff @(posedge sclk) begin
    if (!rsrt) begin
      r_pix_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_img_fin   <= 1'b0;
      r_rgb_rtr   <= 1'b0;
      r_r         <= '0;
      r_g         <= '0;
      r_b         <= '0;
      r_waddr     <= '0;
    end else begin
      r_pix_ready <= (w_state_nxt == ST_WRITE);
      r_busy      <= (w_state_nxt == ST_WRITE);
      // DONE is entered with the final strobe, so this lags that strobe by one cycle.
      r_img_fin   <= (r_state == ST_DONE) && !frame_start;
      r_rgb_rtr   <= w_accept;
      if (w_accept) begin
        r_r     <= bus.pix_r;
        r_g     <= bus.pix_g;
        r_b     <= bus.pix_b;
        r_waddr <= w_addr;
      end
    end
  end

  assign bus.pix_ready  = r_pix_ready;
  assign bus.rgb_rtr    = r_rgb_rtr;
  assign bus.r          = r_r;
  assign bus.g          = r_g;
  assign bus.b          = r_b;
  assign bus.write_addr = r_waddr;
  assign busy           = r_busy;
  assign image_finished = r_img_fin;

endmodule

// File: doc/etc_store_ctrl.md
ETC_STORE_CTRL -- requirements
Module: etc_store_ctrl

Interface
REQ-001 Parameter IMG_W, default 128, image width in pixels; multiple of 4.
REQ-002 Parameter IMG_H, default 128, image height in pixels; multiple of 4.
REQ-003 sclk  in  1  single system clock; all logic on rising edge.
REQ-004 rsrt  in  1  synchronous active-low reset.
REQ-005 frame_start  in  1  one-cycle pulse; begins (or restarts) a frame.
REQ-006 pix_valid  in  1  decoder presents a decoded pixel.
REQ-007 pix_ready  out  1  controller accepts the pixel this cycle.
REQ-008 pix_r, pix_g, pix_b  in  8 each  decoded pixel colour.
REQ-009 r, g, b  out  8 each  registered colour to the image store.
REQ-010 rgb_rtr  out  1  write strobe / enable to the image store.
REQ-011 write_addr  out  32  raster write address; upper bits zero.
REQ-012 image_finished  out  1  frame complete; read port may be enabled.
REQ-013 busy  out  1  high while in WRITE.

Function
REQ-014 States: IDLE, WRITE, DONE; the block SHALL transition only on sclk rising edge.
REQ-015 IDLE->WRITE on frame_start; DONE->WRITE on frame_start; WRITE->WRITE (counters cleared) on frame_start (abort and restart).
REQ-016 pix_ready SHALL equal (state==WRITE) and SHALL not depend combinationally on pix_valid.
REQ-017 A pixel is accepted in cycle N iff pix_valid && pix_ready; in cycle N+1 rgb_rtr=1 with r/g/b and write_addr for that pixel; otherwise rgb_rtr=0 and r/g/b/write_addr hold.
REQ-018 Input order: 4x4 blocks in raster block order (bx fastest), 16 pixels per block with pixel index p in ETC column-major order: x=p[3:2], y=p[1:0].
REQ-019 write_addr = (by*4 + y)*IMG_W + bx*4 + x, computed at full width, zero-extended to 32 bits.
REQ-020 Counters: p wraps 15->0 and increments bx; bx wraps IMG_W/4-1->0 and increments by.
REQ-021 Acceptance of the last pixel (p=15, bx=IMG_W/4-1, by=IMG_H/4-1) SHALL move WRITE->DONE; no further pixels accepted.
REQ-022 image_finished SHALL rise in cycle N+2 after the last acceptance at N (one cycle after the final rgb_rtr), stay high through DONE, and clear the cycle after frame_start.
REQ-023 frame_start coincident with a pixel acceptance: frame_start wins; that pixel is dropped (no rgb_rtr), counters reset to zero.
REQ-024 frame_start in WRITE SHALL clear image_finished (already low) and produce no spurious rgb_rtr.
REQ-025 pix_valid while not in WRITE SHALL be ignored without side effects.

Reset
REQ-026 On sclk edge with rsrt=0: state=IDLE, counters=0, rgb_rtr=0, image_finished=0, busy=0, write_addr=0, r=g=b=0.
REQ-027 Reset mid-frame SHALL abort the frame; a partial frame SHALL never assert image_finished.
REQ-028 frame_start while rsrt=0 SHALL be ignored.

Structure
REQ-029 Shared package etc_pkg SHALL hold IMG_W/IMG_H defaults, ETC block size constant 4, and the state encoding.
REQ-030 One sub-module etc_addr_gen (combinational: bx, by, p -> raster address) SHALL be instantiated; all other logic in etc_store_ctrl.
REQ-031 All outputs SHALL be registered.

Verification
REQ-032 Reset, frame_start, 16 pixels with pix_valid=1 continuous -> rgb_rtr 16 consecutive cycles, addresses 0,128,256,384,1,129,...,387.
REQ-033 Full 128x128 frame, random pix_valid gaps -> exactly 16384 rgb_rtr pulses, each address 0..16383 written once, image_finished high exactly one cycle after final strobe (addr 16383).
REQ-034 Block bx=31,by=0 -> first address 124; block bx=0,by=1 -> first address 512.
REQ-035 frame_start after 1000 accepted pixels, coincident with an acceptance -> no strobe for that pixel, next strobe address 0.
REQ-036 rsrt=0 mid-frame then frame_start -> all outputs zero during reset, addressing restarts at 0, image_finished low until full frame.
REQ-037 frame_start while DONE -> image_finished low next cycle, busy=1, pix_ready=1.
